// File: rtl/mem_stage_pkg.sv
// Bus widths and payload layouts shared by the MEM stage and its neighbours.
package mem_stage_pkg;

   localparam int unsigned ES_TO_MS_BUS_WD = 137;
   localparam int unsigned MS_TO_WS_BUS_WD = 161;
   localparam int unsigned MS_TO_DS_BUS_WD = 39;

   typedef struct packed {
      logic        mem_sign_exted;
      logic [9:0]  excp_num;
      logic        csr_we;
      logic [13:0] csr_idx;
      logic [31:0] csr_result;
      logic        ertn;
      logic        excp;
      logic [1:0]  mem_size;
      logic [3:0]  mul_div_op;
      logic        load_op;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [31:0] pc;
   } es_to_ms_t;

   typedef struct packed {
      logic [31:0] vaddr;
      logic [9:0]  excp_num;
      logic        csr_we;
      logic [13:0] csr_idx;
      logic [31:0] csr_result;
      logic        ertn;
      logic        excp;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic [31:0] pc;
   } ms_to_ws_t;

   typedef struct packed {
      logic        dep_need_stall;
      logic        forward_enable;
      logic [4:0]  dest;
      logic [31:0] final_result;
   } ms_to_ds_t;

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word lane from SRAM read data and extends it.
module load_align (
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata[7:0];
      case (off)
         2'd0: byte_lane = rdata[7:0];
         2'd1: byte_lane = rdata[15:8];
         2'd2: byte_lane = rdata[23:16];
         2'd3: byte_lane = rdata[31:24];
         default: byte_lane = rdata[7:0];
      endcase
      half_lane = off[1] ? rdata[31:16] : rdata[15:0];

      data = rdata;
      if (size[0]) begin
         data = {{24{sign & byte_lane[7]}}, byte_lane};
      end else if (size[1]) begin
         data = {{16{sign & half_lane[15]}}, half_lane};
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX bus, aligns load data, picks mul/div results
// and forwards its result to decode.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_forward_bus,
   output logic                       ms_to_ds_valid,
   output logic                       ms_excp_ertn,
   input  logic [31:0]                data_sram_rdata,
   input  logic [63:0]                mul_result,
   input  logic [31:0]                div_quotient,
   input  logic [31:0]                div_remainder,
   input  logic                       excp_flush,
   input  logic                       ertn_flush
);

   logic        ms_valid;
   logic        ms_ready_go;
   es_to_ms_t   ms_r;
   logic [31:0] load_data;
   logic [31:0] final_result;
   ms_to_ws_t   ws_bus;
   ms_to_ds_t   ds_bus;

   assign ms_ready_go    = 1'b1;
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid && ms_ready_go;
   assign ms_to_ds_valid = ms_valid;
   assign ms_excp_ertn   = ms_valid && (ms_r.excp || ms_r.ertn);

   // Flush from writeback outranks a new instruction arriving the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid <= 1'b0;
      end else if (excp_flush || ertn_flush) begin
         ms_valid <= 1'b0;
      end else if (ms_allowin) begin
         ms_valid <= es_to_ms_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (ms_allowin) begin
         ms_r <= es_to_ms_t'(es_to_ms_bus);
      end
   end

   load_align u_load_align (
      .rdata (data_sram_rdata),
      .off   (ms_r.result[1:0]),
      .size  (ms_r.mem_size),
      .sign  (ms_r.mem_sign_exted),
      .data  (load_data)
   );

   always_comb begin
      final_result = ms_r.result;
      if (ms_r.load_op) begin
         final_result = load_data;
      end else if (ms_r.mul_div_op[0]) begin
         final_result = mul_result[31:0];
      end else if (ms_r.mul_div_op[1]) begin
         final_result = mul_result[63:32];
      end else if (ms_r.mul_div_op[2]) begin
         final_result = div_quotient;
      end else if (ms_r.mul_div_op[3]) begin
         final_result = div_remainder;
      end
   end

   always_comb begin
      ws_bus.vaddr        = ms_r.result;
      ws_bus.excp_num     = ms_r.excp_num;
      ws_bus.csr_we       = ms_r.csr_we;
      ws_bus.csr_idx      = ms_r.csr_idx;
      ws_bus.csr_result   = ms_r.csr_result;
      ws_bus.ertn         = ms_r.ertn;
      ws_bus.excp         = ms_r.excp;
      ws_bus.gr_we        = ms_r.gr_we && !ms_r.excp;
      ws_bus.dest         = ms_r.dest;
      ws_bus.final_result = final_result;
      ws_bus.pc           = ms_r.pc;
   end

   // MEM results are always final, so decode never has to stall on this stage.
   always_comb begin
      ds_bus.dep_need_stall = 1'b0;
      ds_bus.forward_enable = ms_valid && ms_r.gr_we && !ms_r.excp && (ms_r.dest != 5'd0);
      ds_bus.dest           = ms_r.dest;
      ds_bus.final_result   = final_result;
   end

   assign ms_to_ws_bus         = ws_bus;
   assign ms_to_ds_forward_bus = ds_bus;

endmodule
